// File: rtl/vliw_fetch_unit.sv
// VLIW instruction fetch: PC register feeding a QUEUE_DEPTH-entry fetch queue towards decode.
// Latency: imem hit at edge N is visible on fd_* after edge N; imem_addr is the registered PC.
// Backpressure: a full queue with no pop stalls the PC; misses hold the PC; fd_* never depend on fd_ready.
// Ports: i_clk/i_reset (async, active-high); i_fetch_en, i_flush, i_redirect (00 none, 01 branch,
//   10 jump, 11 exception) with i_branch_target/i_jump_target; o_imem_addr, i_imem_hit,
//   i_imem_rdata (slot 0 in the top SLOT_W bits); o_fd_valid/i_fd_ready, o_fd_bundle, o_fd_pc_next;
//   o_queue_count (occupancy), o_miss_count (saturating miss-cycle counter).
module vliw_fetch_unit #(
  parameter int                SLOTS       = 2,
  parameter int                SLOT_W      = 16,
  parameter int                ADDR_W      = 32,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       EXC_ADDR    = 32'h00FF00FF
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_fetch_en,
  input  logic                          i_flush,
  input  logic [1:0]                    i_redirect,
  input  logic [ADDR_W-1:0]             i_branch_target,
  input  logic [ADDR_W-1:0]             i_jump_target,
  output logic [ADDR_W-1:0]             o_imem_addr,
  input  logic                          i_imem_hit,
  input  logic [SLOTS*SLOT_W-1:0]       i_imem_rdata,
  output logic                          o_fd_valid,
  input  logic                          i_fd_ready,
  output logic [SLOTS*SLOT_W-1:0]       o_fd_bundle,
  output logic [ADDR_W-1:0]             o_fd_pc_next,
  output logic [$clog2(QUEUE_DEPTH):0]  o_queue_count,
  output logic [15:0]                   o_miss_count
);

  localparam int                PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int                CNT_W  = PTR_W + 1;
  localparam int                DATA_W = SLOTS * SLOT_W;
  localparam int                BYTES  = DATA_W / 8;
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_ADDR);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_miss;
  logic [DATA_W-1:0] r_q_bundle [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_q_pc_next [QUEUE_DEPTH];

  logic              w_redir;
  logic              w_clear;
  logic              w_pop;
  logic              w_full;
  logic              w_do_fetch;
  logic              w_do_pop;
  logic              w_miss;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;

  assign w_redir  = |i_redirect;
  assign w_clear  = w_redir | i_flush;
  assign w_pop    = o_fd_valid & i_fd_ready;
  assign w_full   = (r_count == CNT_W'(QUEUE_DEPTH));
  // A pop frees a slot in the same cycle, so a full queue still accepts a fetch.
  assign w_do_fetch = ~w_clear & i_fetch_en & i_imem_hit & (~w_full | w_pop);
  // Redirect/flush empties the queue, which overrides any handshake in that cycle.
  assign w_do_pop   = ~w_clear & w_pop;
  assign w_miss     = i_fetch_en & ~i_imem_hit & ~w_clear;
  assign w_pc_inc   = r_pc + ADDR_W'(BYTES);

  always_comb begin
    w_target = EXC_PC;
    case (i_redirect)
      2'b01:   w_target = i_branch_target;
      2'b10:   w_target = i_jump_target;
      default: w_target = EXC_PC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (w_redir) begin
      r_pc <= w_target;
    end else if (w_do_fetch) begin
      r_pc <= w_pc_inc;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_miss <= '0;
    end else if (w_miss && (r_miss != 16'hFFFF)) begin
      r_miss <= r_miss + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_fetch) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_fetch && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_fetch && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge i_clk) begin
    if (w_do_fetch) begin
      r_q_bundle[r_wr_ptr]  <= i_imem_rdata;
      r_q_pc_next[r_wr_ptr] <= w_pc_inc;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_fd_valid    = (r_count != '0);
  assign o_fd_bundle   = o_fd_valid ? r_q_bundle[r_rd_ptr]  : '0;
  assign o_fd_pc_next  = o_fd_valid ? r_q_pc_next[r_rd_ptr] : '0;
  assign o_queue_count = r_count;
  assign o_miss_count  = r_miss;

endmodule

// File: doc/vliw_fetch_unit.md
# vliw_fetch_unit

Parametrised instruction-fetch stage for the VLIW core. It generalises the two-slot fetch stage to SLOTS issue slots and replaces the single IF/ID register with a QUEUE_DEPTH-entry fetch queue. The queue has a valid/ready handshake to decode, stalls on instruction-memory misses, and redirects the PC on branch, jump or exception with queue flush. It sits between the instruction memory and the decode stage.

## Interface
- SLOTS, 2, instructions per bundle (≥1)
- SLOT_W, 16, bits per instruction
- ADDR_W, 32, PC width
- QUEUE_DEPTH, 4, fetch-queue entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- EXC_ADDR, 32'h00FF00FF, exception handler address (truncated to ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fetch_en  in  1  PC-write enable; 0 holds the PC and suppresses enqueue
- flush  in  1  discard queue contents and this cycle's fetch
- redirect  in  2  00 none, 01 branch, 10 jump, 11 exception
- branch_target  in  ADDR_W  target for redirect=01
- jump_target  in  ADDR_W  target for redirect=10
- imem_addr  out  ADDR_W  current PC
- imem_hit  in  1  imem_rdata valid for imem_addr this cycle
- imem_rdata  in  SLOTS*SLOT_W  fetched bundle; slot 0 is the most-significant SLOT_W bits
- fd_valid  out  1  queue head valid
- fd_ready  in  1  decode accepts head
- fd_bundle  out  SLOTS*SLOT_W  head bundle, same slot order as imem_rdata
- fd_pc_next  out  ADDR_W  head bundle address + BYTES
- queue_count  out  clog2(QUEUE_DEPTH)+1  occupied entries
- miss_count  out  16  saturating count of cycles with fetch_en=1, imem_hit=0 and no redirect/flush

## Operation
- BYTES = SLOTS*SLOT_W/8. PC arithmetic is modulo 2^ADDR_W; PC+BYTES wraps silently.
- Per-cycle priority, highest first:
  - reset
  - redirect≠00: PC ← selected target and queue emptied. No enqueue. Applies even when fetch_en=0.
  - flush: queue emptied, no enqueue, PC held.
  - normal fetch: `do_fetch = fetch_en & imem_hit & (count<QUEUE_DEPTH | pop)`. On do_fetch, enqueue {imem_rdata, PC+BYTES} and PC ← PC+BYTES. Otherwise PC holds.
- `pop = fd_valid & fd_ready`. Pop is ignored in cycles with redirect or flush, since the queue is cleared.
- Full queue with simultaneous pop and fetch: both occur and the count is unchanged.
- Empty queue: fd_valid=0, and fd_bundle and fd_pc_next are driven to 0. There is no bypass from imem to fd.
- miss_count saturates at 16'hFFFF.
- Redirect encoding 11 uses EXC_ADDR; branch_target and jump_target are ignored in that cycle.

## Timing
- Reset values:
  - PC=RESET_PC, so imem_addr=RESET_PC
  - queue empty, queue_count=0, fd_valid=0, fd_bundle=0, fd_pc_next=0
  - miss_count=0
- Fetch-to-decode latency is 1 cycle. A hit at edge N gives fd_valid=1 after edge N.
- Redirect at edge N:
  - imem_addr=target after edge N.
  - The first target bundle is visible on fd after edge N+1 if that cycle hits.
- fd_* are register/queue outputs only and have no combinational path from fd_ready. imem_addr is a register output.
- Throughput: one bundle per cycle while hits continue and decode is ready.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Handshake:
  - fd_bundle and fd_pc_next stay stable while fd_valid=1 and fd_ready=0.
  - fd_valid never drops without a pop, flush or redirect.

## Test plan
- **Reset and streaming.** After reset, imem_hit=1 with rdata=32'hA000_B000+PC, fd_ready=1.
  - imem_addr sequence is 0,4,8,…
  - fd_valid rises one cycle after the first hit.
  - fd_pc_next sequence is 4,8,12,…
  - fd_bundle is 32'hA000_B000, 32'hA000_B004, …
- **Backpressure.** fd_ready=0 with continuous hits.
  - queue_count climbs to 4, then PC freezes at 16.
  - The head holds rdata from address 0.
  - Raising fd_ready for one cycle pops one entry and fetches address 16 in the same cycle; count stays 4.
- **Miss stall.** imem_hit=0 for 3 cycles at PC=8, fetch_en=1.
  - PC holds at 8.
  - miss_count rises by 3.
  - No enqueue occurs.
  - Fetch resumes at 8 when the hit returns.
- **Redirect priority and flush.** Queue holds 3 entries; redirect=11 together with flush=1 and a hit.
  - Queue empties and fd_valid=0 next cycle.
  - PC=32'h00FF00FF.
  - The next cycle's hit enqueues with fd_pc_next=32'h00FF0103.
  - Repeat with redirect=01, branch_target=32'h40: PC=32'h40.
- **Wrap and parameters.** SLOTS=4, RESET_PC=32'hFFFF_FFF8.
  - PC steps to 32'h0000_0000 on the next hit (BYTES=8).
  - fd_bundle is 64 bits wide with slot 0 in bits [63:48].
- **Async reset mid-stream.** Assert reset between edges while count=2.
  - Outputs reach their reset values before the next edge.
  - miss_count=0.
